// File: rtl/hoplite_pe_inject_arb.sv
// Round-robin injection arbiter feeding the PE port of a Hoplite torus switch.
// A one-entry output register holds each packet until the switch accepts it.
module hoplite_pe_inject_arb #(
  parameter int N_REQ      = 4,
  parameter int D_W        = 4,
  parameter int A_W        = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*A_W-1:0] req_addr,
  input  logic [N_REQ*D_W-1:0] req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 pe_in_valid,
  output logic [A_W-1:0]       pe_in_addr,
  output logic [D_W-1:0]       pe_in_data,
  input  logic                 pe_ready,
  output logic                 starve,
  output logic [15:0]          inj_count
);

  localparam int P_W  = $clog2(N_REQ);
  localparam int WC_W = $clog2(STARVE_MAX + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(STARVE_MAX);

  logic [P_W-1:0]  rr_ptr;
  logic [WC_W-1:0] wait_cnt;
  logic [P_W-1:0]  win;
  logic            has_win;
  logic            free;
  logic            capture;
  logic            accept;

  // Modulo-N_REQ increment that also works when N_REQ is not a power of two.
  function automatic logic [P_W-1:0] wrap_add(input logic [P_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_REQ) s = s - N_REQ;
    return P_W'(s);
  endfunction

  always_comb begin
    has_win = 1'b0;
    win     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!has_win && req_valid[wrap_add(rr_ptr, i)]) begin
        has_win = 1'b1;
        win     = wrap_add(rr_ptr, i);
      end
    end
  end

  assign free    = !pe_in_valid || pe_ready;
  assign capture = free && has_win;
  assign accept  = pe_in_valid && pe_ready;

  always_comb begin
    req_ready = '0;
    if (!rst && capture) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_in_valid <= 1'b0;
      pe_in_addr  <= '0;
      pe_in_data  <= '0;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      starve      <= 1'b0;
      inj_count   <= '0;
    end else begin
      if (capture) begin
        pe_in_valid <= 1'b1;
        pe_in_addr  <= req_addr[win*A_W +: A_W];
        pe_in_data  <= req_data[win*D_W +: D_W];
        rr_ptr      <= wrap_add(win, 1);
      end else if (accept) begin
        pe_in_valid <= 1'b0;
      end

      if (accept) begin
        inj_count <= inj_count + 16'd1;
        wait_cnt  <= '0;
      end else if (pe_in_valid && wait_cnt != WC_MAX) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end

      // Gated by accept so the flag drops on the cycle right after the handoff.
      starve <= !accept && (wait_cnt == WC_MAX);
    end
  end

endmodule

// File: tb/tb_hoplite_pe_inject_arb.sv
// Directed bench for hoplite_pe_inject_arb: single request, round-robin wrap,
// backpressure/starve, reset mid-hold and injection counter wrap.
module tb_hoplite_pe_inject_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        pe_in_valid;
  logic [3:0]  pe_in_addr;
  logic [3:0]  pe_in_data;
  logic        pe_ready;
  logic        starve;
  logic [15:0] inj_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hoplite_pe_inject_arb #(.N_REQ(4), .D_W(4), .A_W(4), .STARVE_MAX(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .pe_in_valid(pe_in_valid),
    .pe_in_addr (pe_in_addr),
    .pe_in_data (pe_in_data),
    .pe_ready   (pe_ready),
    .starve     (starve),
    .inj_count  (inj_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester addresses: r0=8 r1=9 r2=5 r3=B; data: r0=1 r1=2 r2=A r3=4
  logic [3:0] addr_of [4] = '{4'h8, 4'h9, 4'h5, 4'hB};
  logic [3:0] data_of [4] = '{4'h1, 4'h2, 4'hA, 4'h4};
  int         rr_grant [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_addr  = 16'hB598;
    req_data  = 16'h4A21;
    pe_ready  = 1'b1;

    // Reset behaviour
    @(negedge clk);
    chk("ready_in_rst", 32'(req_ready), 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 32'(pe_in_valid), 32'h0);
    chk("rst_addr", 32'(pe_in_addr), 32'h0);
    chk("rst_data", 32'(pe_in_data), 32'h0);
    chk("rst_starve", 32'(starve), 32'h0);
    chk("rst_inj", 32'(inj_count), 32'h0);
    $display("txn reset: ready=%b valid=%b inj=%0d", req_ready, pe_in_valid, inj_count);

    // Single requester 2, first cycle out of reset
    tick();
    rst = 1'b0; req_valid = 4'b0100; pe_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", 32'(pe_in_valid), 32'h1);
    chk("single_addr", 32'(pe_in_addr), 32'h5);
    chk("single_data", 32'(pe_in_data), 32'hA);
    chk("single_ready_idle", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("single_empty", 32'(pe_in_valid), 32'h0);
    chk("single_inj", 32'(inj_count), 32'h1);
    chk("single_rrptr", 32'(dut.rr_ptr), 32'h3);
    $display("txn single: addr=%h data=%h inj=%0d", pe_in_addr, pe_in_data, inj_count);

    // Wrap and fairness: pointer at 3, requesters 0 and 3 -> 3,0,3
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    chk("wrap_g0", 32'(req_ready), 32'h8);
    tick();
    @(negedge clk);
    chk("wrap_g1", 32'(req_ready), 32'h1);
    chk("wrap_addr1", 32'(pe_in_addr), 32'hB);
    chk("wrap_inj1", 32'(inj_count), 32'h1);
    tick();
    @(negedge clk);
    chk("wrap_g2", 32'(req_ready), 32'h8);
    chk("wrap_addr2", 32'(pe_in_addr), 32'h8);
    chk("wrap_inj2", 32'(inj_count), 32'h2);
    $display("txn wrap: grants 3,0,3 inj=%0d", inj_count);

    // Round robin with all four valid, pointer now 0
    for (int k = 0; k < 6; k++) begin
      tick();
      req_valid = 4'hF;
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_grant[k]));
      chk("rr_valid", 32'(pe_in_valid), 32'h1);
      chk("rr_inj", 32'(inj_count), 32'(k + 3));
      chk("rr_addr", 32'(pe_in_addr), 32'(k == 0 ? 4'hB : addr_of[rr_grant[k-1]]));
      $display("txn rr: k=%0d ready=%b addr=%h inj=%0d", k, req_ready, pe_in_addr, inj_count);
    end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rr_last_addr", 32'(pe_in_addr), 32'h9);
    chk("rr_last_inj", 32'(inj_count), 32'd9);
    tick();
    @(negedge clk);
    chk("rr_drain", 32'(pe_in_valid), 32'h0);
    chk("rr_drain_inj", 32'(inj_count), 32'd10);

    // Backpressure: pointer 2, requester 0 only -> grant 0, then refused 20 cycles
    tick();
    req_valid = 4'b0001; pe_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      req_valid = 4'hF;
      @(negedge clk);
      chk("bp_valid", 32'(pe_in_valid), 32'h1);
      chk("bp_addr", 32'(pe_in_addr), 32'(addr_of[0]));
      chk("bp_data", 32'(pe_in_data), 32'(data_of[0]));
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_starve", 32'(starve), 32'(k >= 17));
      $display("txn bp: k=%0d starve=%b ready=%b", k, starve, req_ready);
    end
    tick();
    req_valid = 4'b0000; pe_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", 32'(pe_in_valid), 32'h1);
    chk("bp_accept_starve", 32'(starve), 32'h1);
    tick();
    @(negedge clk);
    chk("bp_after_valid", 32'(pe_in_valid), 32'h0);
    chk("bp_after_starve", 32'(starve), 32'h0);
    chk("bp_after_inj", 32'(inj_count), 32'd11);

    // Reset mid-hold: pointer 1, requester 2 captured and held
    tick();
    req_valid = 4'b0100; pe_ready = 1'b0;
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'hF; rst = 1'b1;
    @(negedge clk);
    chk("mid_ready_rst", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0; pe_ready = 1'b1;
    @(negedge clk);
    chk("mid_valid", 32'(pe_in_valid), 32'h0);
    chk("mid_addr", 32'(pe_in_addr), 32'h0);
    chk("mid_data", 32'(pe_in_data), 32'h0);
    chk("mid_inj", 32'(inj_count), 32'h0);
    chk("mid_grant0", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
    chk("mid_pkt_addr", 32'(pe_in_addr), 32'h8);
    chk("mid_pkt_inj", 32'(inj_count), 32'h0);
    $display("txn midreset: addr=%h inj=%0d", pe_in_addr, inj_count);

    // Counter wrap: one accept per cycle from here
    for (int k = 0; k < 65535; k++) tick();
    @(negedge clk);
    chk("wrap_ffff", 32'(inj_count), 32'hFFFF);
    tick();
    @(negedge clk);
    chk("wrap_zero", 32'(inj_count), 32'h0);
    chk("wrap_starve", 32'(starve), 32'h0);
    $display("txn cntwrap: inj=%0d starve=%b", inj_count, starve);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hoplite_pe_inject_arb.md
# hoplite_pe_inject_arb

Injection arbiter between several client requesters and the PE port of one Hoplite torus switch. It gives the single PE injection port to the requesters in round-robin order and holds each packet in a one-entry output register until the switch accepts it. The switch accepts a PE packet only when deflection traffic leaves room. The arbiter also counts injections and flags a starved injection. It sits between the PE-side clients and the switch's `pe_in_*`/`ready` pins.

## Interface
- `N_REQ`, default 4: number of requesters. Must be ≥ 2.
- `D_W`, default 4: packet data width.
- `A_W`, default 4: packet address width. Passed through unmodified.
- `STARVE_MAX`, default 15: number of consecutive refused cycles at which `starve` asserts. Must be ≥ 1.
- `clk` in 1: clock. Everything is clocked on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N_REQ: per-requester packet valid.
- `req_addr` in N_REQ*A_W: requester i occupies bits [i*A_W +: A_W].
- `req_data` in N_REQ*D_W: requester i occupies bits [i*D_W +: D_W].
- `req_ready` out N_REQ: combinational one-hot accept. A packet transfers on `req_valid[i] & req_ready[i]`.
- `pe_in_valid` out 1: to switch PE valid. Registered.
- `pe_in_addr` out A_W: to switch PE address. Registered.
- `pe_in_data` out D_W: to switch PE data. Registered.
- `pe_ready` in 1: switch accepted the PE packet this cycle. Meaningful only while `pe_in_valid` is high.
- `starve` out 1: the current packet has been refused for STARVE_MAX consecutive cycles. Registered.
- `inj_count` out 16: total packets accepted by the switch. Wraps modulo 2^16.

## Operation
- State:
  - Output register `{pe_in_valid, pe_in_addr, pe_in_data}`.
  - Round-robin pointer `rr_ptr`, $clog2(N_REQ) bits.
  - Grant index `g`.
  - Wait counter `wait_cnt`, wide enough for STARVE_MAX.
  - `inj_count`.
- Two states:
  - EMPTY: `pe_in_valid` = 0.
  - HOLD: `pe_in_valid` = 1.
- Slot free condition: `free = !pe_in_valid | pe_ready`. The register is empty, or its packet leaves this cycle.
- Winner selection is combinational.
  - Scan order is `rr_ptr`, `rr_ptr`+1, … modulo N_REQ.
  - The winner is the first requester with `req_valid` = 1.
  - `req_ready[winner]` = `free`. All other `req_ready` bits are 0.
  - When no request is pending, all `req_ready` bits are 0.
- Capture: on `free` with a winner, the winner's addr/data load the register. Then `pe_in_valid` ← 1, `g` ← winner, `rr_ptr` ← (winner+1) mod N_REQ.
- Accept: when `pe_in_valid & pe_ready`, `inj_count` increments and `wait_cnt` ← 0.
  - If the same cycle has no capture, `pe_in_valid` ← 0 (HOLD→EMPTY).
  - If the same cycle has a capture, the state stays HOLD with the new packet.
- Refuse: when `pe_in_valid & !pe_ready`, the register holds its value bit-for-bit stable. `wait_cnt` increments and saturates at STARVE_MAX.
- `starve` is registered `(wait_cnt == STARVE_MAX)`. It clears the cycle after acceptance.
- `rr_ptr` advances only on capture. An idle cycle never moves it.
- A requester that drops `req_valid` without a handshake is simply skipped. The arbiter keeps no per-requester memory.
- Reset: all outputs and state are zero.
  - `pe_in_valid`, `pe_in_addr`, `pe_in_data`, `starve`, `inj_count`, `rr_ptr`, `wait_cnt` = 0.
  - `req_ready` = 0 while `rst` is high.
  - A packet held at reset is discarded and is not counted.

## Timing
- Request-to-switch latency is 1 cycle. Handshake at edge t gives `pe_in_valid` = 1 in cycle t+1.
- Throughput is 1 packet/cycle while `pe_ready` stays high (back-to-back capture on accept).
- `req_ready` depends combinationally on `req_valid`, `pe_ready`, `pe_in_valid` and `rr_ptr`.
- The switch must not make `pe_ready` depend on `req_*`, so that no combinational loop forms.
- First capture is allowed in the first cycle with `rst` = 0.
- Starve onset: the packet is first presented in cycle t and refused every cycle. `wait_cnt` reaches STARVE_MAX at edge t+STARVE_MAX. `starve` = 1 from cycle t+STARVE_MAX+1.
- `inj_count` wraps from 16'hFFFF to 0 and `starve` is unaffected by the wrap.

## Test plan
- Single requester: `req_valid[2]`=1 with addr 4'h5, data 4'hA for one cycle, `pe_ready`=1.
  - `req_ready` = 4'b0100 in that cycle.
  - Next cycle: `pe_in_valid`=1, addr 5, data A.
  - The cycle after: `pe_in_valid`=0, `inj_count`=1, `rr_ptr`=3.
- Round-robin: all four requesters hold valid, `pe_ready`=1.
  - Grants go 0,1,2,3,0,1 on consecutive cycles.
  - `pe_in_valid` stays high continuously and `inj_count` increments every cycle.
- Wrap and fairness: `rr_ptr`=3, only requesters 0 and 3 valid. Grant goes to 3, then 0, then 3.
- Backpressure: one packet with `pe_ready`=0 for 20 cycles, then 1.
  - `pe_in_addr`/`pe_in_data` stay stable throughout.
  - All `req_ready` bits are 0 while it is held.
  - `starve` rises 16 cycles after first presentation (STARVE_MAX = 15).
  - `starve` falls the cycle after acceptance.
- Reset mid-hold: packet held with `pe_ready`=0 and `rst` pulsed for 1 cycle.
  - Next cycle: all outputs are 0 and `inj_count`=0.
  - The next grant starts from requester 0.
- Counter wrap: force or preload 65535 accepts, then 1 more accept. `inj_count` reads 0.
